// File: rtl/ula_sequencial.sv
// ula_sequencial: datapath ALU driven by the 4-bit ULActl code from ALU control.
// The single-cycle ops write their result on the cycle after start is accepted.
// mul, div and rem are iterative, one bit per clock. The start/busy/done
// handshake lets the control unit stall the processor while they run.
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   start            request, sampled only while idle
//   ULActl           operation code
//   A, B             operands (B[4:0] is the shift amount for the shifts)
//   resultado, zero  registered result and its zero flag, held until the next done
//   busy             high from acceptance of a multi-cycle op until done falls
//   done             one-cycle pulse when resultado/zero/erro are updated
//   erro             invalid code or divide by zero, held with resultado
module ula_sequencial #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       ULActl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] resultado,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             erro
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010, OP_SRL = 4'b0011,
    OP_MUL = 4'b0100, OP_DIV = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111,
    OP_LUI = 4'b1000, OP_REM = 4'b1001, OP_NOT = 4'b1100, OP_SLL = 4'b1110
  } op_e;

  state_e state, state_next;
  op_e    op;

  logic [CW-1:0]    cnt;
  // acc: partial product or partial remainder.
  // opa: shifted multiplicand, or dividend shifting out while the quotient shifts in.
  // opb: multiplier shifting right, or the divisor.
  logic [WIDTH-1:0] acc, opa, opb;

  logic [WIDTH-1:0] imm_res;
  logic             imm_err;
  logic             multi;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem, div_quo, exec_res;
  logic             last;

  // Result of every op that completes without iterating, including the error cases.
  always_comb begin
    imm_res = '0;
    imm_err = 1'b0;
    multi   = 1'b0;
    case (ULActl)
      OP_ADD: imm_res = A + B;
      OP_SUB: imm_res = A - B;
      OP_AND: imm_res = A & B;
      OP_OR:  imm_res = A | B;
      OP_NOT: imm_res = ~A;
      OP_SLT: imm_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL: imm_res = A << B[4:0];
      OP_SRL: imm_res = A >> B[4:0];
      OP_LUI: imm_res = B << (WIDTH/2);
      OP_MUL: multi = 1'b1;
      OP_DIV, OP_REM: begin
        if (B == '0) begin
          imm_err = 1'b1;
          imm_res = (ULActl == OP_DIV) ? '1 : A;
        end else begin
          multi = 1'b1;
        end
      end
      default: imm_err = 1'b1;
    endcase
  end

  // One iteration step: shift-add for mul, restoring step for div/rem.
  always_comb begin
    mul_acc   = acc + (opb[0] ? opa : '0);
    div_trial = {acc, opa[WIDTH-1]} - {1'b0, opb};
    div_ok    = ~div_trial[WIDTH];
    div_rem   = div_ok ? div_trial[WIDTH-1:0] : {acc[WIDTH-2:0], opa[WIDTH-1]};
    div_quo   = {opa[WIDTH-2:0], div_ok};
    last      = (cnt == CW'(WIDTH-1));
    case (op)
      OP_MUL:  exec_res = mul_acc;
      OP_DIV:  exec_res = div_quo;
      default: exec_res = div_rem;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = multi ? S_EXEC : S_DONE;
      S_EXEC:  if (last) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op        <= OP_AND;
      cnt       <= '0;
      acc       <= '0;
      opa       <= '0;
      opb       <= '0;
      resultado <= '0;
      zero      <= 1'b1;
      erro      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cnt <= '0;
          if (multi) begin
            op  <= op_e'(ULActl);
            acc <= '0;
            opa <= A;
            opb <= B;
          end else begin
            resultado <= imm_res;
            zero      <= (imm_res == '0);
            erro      <= imm_err;
          end
        end
        S_EXEC: begin
          cnt <= cnt + 1'b1;
          if (op == OP_MUL) begin
            acc <= mul_acc;
            opa <= opa << 1;
            opb <= opb >> 1;
          end else begin
            acc <= div_rem;
            opa <= div_quo;
          end
          if (last) begin
            resultado <= exec_res;
            zero      <= (exec_res == '0);
            erro      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequencial.sv
module tb_ula_sequencial;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ULActl = 4'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] resultado;
  logic        zero, busy, done, erro;

  int checks = 0;
  int fails  = 0;

  logic [3:0] single_ops [9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100,
                                 4'b0111, 4'b1110, 4'b0011, 4'b1000};
  logic [3:0] multi_ops  [3] = '{4'b0100, 4'b0101, 4'b1001};

  ula_sequencial #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ULActl(ULActl),
    .A(A), .B(B), .resultado(resultado), .zero(zero), .busy(busy),
    .done(done), .erro(erro)
  );

  always #5 clock = ~clock;

  // Reference behaviour: plain arithmetic on the op code.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output int lat);
    logic [63:0] p;
    r = '0; e = 1'b0; lat = 1;
    case (op)
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~a;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1110: r = a << b[4:0];
      4'b0011: r = a >> b[4:0];
      4'b1000: r = b << 16;
      4'b0100: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; lat = 33; end
      4'b0101: if (b == 0) begin r = 32'hFFFF_FFFF; e = 1'b1; end else begin r = a / b; lat = 33; end
      4'b1001: if (b == 0) begin r = a; e = 1'b1; end else begin r = a % b; lat = 33; end
      default: e = 1'b1;
    endcase
  endfunction

  // Issues one op and waits for done. lat counts clock edges from the accepting
  // edge (inclusive) to the edge after which done is seen; 999 on timeout.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic changed);
    logic [31:0] prev;
    int guard;
    changed = 1'b0; lat = 999; guard = 0;
    @(negedge clock);
    while (busy && guard < 100) begin @(negedge clock); guard++; end
    prev = resultado;
    start = 1'b1; ULActl = op; A = a; B = b;
    @(posedge clock); #1;
    start = 1'b0; ULActl = 4'b1111; A = $urandom; B = $urandom;
    for (int i = 1; i <= 100; i++) begin
      if (done) begin lat = i; break; end
      if (resultado !== prev) changed = 1'b1;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, erro, zero, resultado} !== {1'b0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b erro=%b zero=%b res=%h, want 0 0 0 1 0",
               busy, done, erro, zero, resultado);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] op; logic [31:0] a, b, er; logic ee; int el, lat; logic ch;
    logic [3:0]  d_op [5] = '{4'b0010, 4'b0110, 4'b0111, 4'b1110, 4'b1000};
    logic [31:0] d_a  [5] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd1, 32'd0};
    logic [31:0] d_b  [5] = '{32'd1, 32'd5, 32'd1, 32'd31, 32'h1234};
    for (int n = 0; n < 45; n++) begin
      if (n < 5) begin op = d_op[n]; a = d_a[n]; b = d_b[n]; end
      else begin
        op = single_ops[$urandom_range(0, 8)];
        a = (n % 7 == 0) ? b : $urandom;
        b = (n % 5 == 0) ? {27'd0, 5'($urandom)} : $urandom;
      end
      model(op, a, b, er, ee, el);
      run_op(op, a, b, lat, ch);
      checks++;
      if (resultado !== er || zero !== (er == 0) || erro !== ee) begin
        fails++;
        $display("FAIL single op=%b a=%h b=%h: got res=%h zero=%b erro=%b, want res=%h zero=%b erro=%b",
                 op, a, b, resultado, zero, erro, er, (er == 0), ee);
      end
      checks++;
      if (lat !== el) begin
        fails++;
        $display("FAIL single_latency op=%b: got %0d, want %0d", op, lat, el);
      end
    end
  endtask

  task automatic test_multi();
    logic [3:0] op; logic [31:0] a, b, er; logic ee; int el, lat; logic ch;
    logic [3:0]  d_op [3] = '{4'b0100, 4'b0101, 4'b1001};
    logic [31:0] d_a  [3] = '{32'hFFFF, 32'h64, 32'h64};
    logic [31:0] d_b  [3] = '{32'h10001, 32'd7, 32'd7};
    for (int n = 0; n < 15; n++) begin
      if (n < 3) begin op = d_op[n]; a = d_a[n]; b = d_b[n]; end
      else begin
        op = multi_ops[$urandom_range(0, 2)];
        a = $urandom;
        b = (n % 2 == 0) ? 32'($urandom_range(1, 255)) : ($urandom | 32'd1);
      end
      model(op, a, b, er, ee, el);
      run_op(op, a, b, lat, ch);
      checks++;
      if (resultado !== er || zero !== (er == 0) || erro !== ee) begin
        fails++;
        $display("FAIL multi op=%b a=%h b=%h: got res=%h zero=%b erro=%b, want res=%h zero=%b erro=%b",
                 op, a, b, resultado, zero, erro, er, (er == 0), ee);
      end
      checks++;
      if (lat !== el || ch !== 1'b0) begin
        fails++;
        $display("FAIL multi_timing op=%b: got lat=%0d changed_early=%b, want lat=%0d changed_early=0",
                 op, lat, ch, el);
      end
    end
  endtask

  task automatic test_error_cases();
    logic [3:0] op; logic [31:0] a, er; logic ee; int el, lat; logic ch;
    logic [3:0] codes [6] = '{4'b0101, 4'b1001, 4'b1111, 4'b1010, 4'b1011, 4'b1101};
    for (int n = 0; n < 7; n++) begin
      a = (n == 0) ? 32'd9 : $urandom;
      op = (n < 6) ? codes[n] : 4'b0010;
      model(op, a, (n < 2) ? 32'd0 : 32'd3, er, ee, el);
      run_op(op, a, (n < 2) ? 32'd0 : 32'd3, lat, ch);
      checks++;
      if (resultado !== er || zero !== (er == 0) || erro !== ee || lat !== el) begin
        fails++;
        $display("FAIL error_case op=%b a=%h: got res=%h zero=%b erro=%b lat=%0d, want res=%h zero=%b erro=%b lat=%0d",
                 op, a, resultado, zero, erro, lat, er, (er == 0), ee, el);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clock);
    while (busy) @(negedge clock);
    start = 1'b1; ULActl = 4'b0100; A = 32'd12345; B = 32'd678;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    start = 1'b1; ULActl = 4'b0010; A = 32'd1; B = 32'd1;
    @(negedge clock);
    start = 1'b0;
    lat = 999;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (done) begin lat = i; break; end
    end
    checks++;
    if (resultado !== 32'd8369910 || lat === 999) begin
      fails++;
      $display("FAIL ignore_start_result: got res=%h (timeout=%b), want %h", resultado, lat == 999, 32'd8369910);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_start_after_done: got done=%b busy=%b, want 0 0", done, busy);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_start_not_queued: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er, ea, eb; logic ee; int el; logic [3:0] op, eop;
    @(negedge clock);
    while (busy) @(negedge clock);
    eop = 4'b0010; ea = 0; eb = 0;
    for (int k = 0; k < 8; k++) begin
      op = single_ops[$urandom_range(0, 8)];
      start = 1'b1; ULActl = op; A = $urandom; B = $urandom;
      if (k % 2 == 0) begin eop = op; ea = A; eb = B; end
      @(posedge clock); #1;
      model(eop, ea, eb, er, ee, el);
      checks++;
      if (done !== (k % 2 == 0) || resultado !== er) begin
        fails++;
        $display("FAIL back_to_back k=%0d: got done=%b res=%h, want done=%b res=%h",
                 k, done, resultado, (k % 2 == 0), er);
      end
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    int lat; logic ch;
    run_op(4'b0010, 32'd7, 32'd1, lat, ch);
    @(negedge clock);
    while (busy) @(negedge clock);
    start = 1'b1; ULActl = 4'b0100; A = 32'hFFFF; B = 32'h10001;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, erro, zero, resultado} !== {1'b0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
      fails++;
      $display("FAIL reset_mid_mul: got busy=%b done=%b erro=%b zero=%b res=%h, want 0 0 0 1 0",
               busy, done, erro, zero, resultado);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || resultado !== 32'd0) begin
      fails++;
      $display("FAIL reset_aborts_op: got busy=%b res=%h, want busy=0 res=0", busy, resultado);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_error_cases();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
